// File: rtl/pixel_window_loader_if.sv
// Read-side bus between the window loader and the input-frame BRAM.
// The loader is the master: it issues enable/address and receives data one cycle later.
interface pixel_window_loader_if #(
  parameter int PIX_WIDTH  = 8,
  parameter int ADDR_WIDTH = 20
);
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [PIX_WIDTH-1:0]  bram_dout;

  modport master (output bram_en, output bram_addr, input  bram_dout);
  modport slave  (input  bram_en, input  bram_addr, output bram_dout);
endinterface

// File: rtl/pixel_window_loader.sv
// 3x3 pixel window loader: fetches input-frame pixels from BRAM on each request,
// slides one column per request, restarts at column 0 of the next row on new_line,
// and presents the window as a registered output with a one-cycle ack pulse.
module pixel_window_loader #(
  parameter int PIX_WIDTH      = 8,
  parameter int DIMM_BUS_WIDTH = 16,
  parameter int ADDR_WIDTH     = 20
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [DIMM_BUS_WIDTH-1:0] frame_input_width,
  input  logic [DIMM_BUS_WIDTH-1:0] frame_input_height,
  input  logic                      start,
  input  logic                      req_pix,
  input  logic                      new_line,
  output logic                      pix_ctrl_ack,
  output logic [9*PIX_WIDTH-1:0]    window,
  pixel_window_loader_if.master     bram,
  output logic                      overrun
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_ACK      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW = 2'd3;

  localparam logic [DIMM_BUS_WIDTH-1:0] MIN_DIM   = 3;
  localparam logic [DIMM_BUS_WIDTH:0]   EDGE_STEP = 4;

  logic [1:0]                state;
  logic [DIMM_BUS_WIDTH-1:0] width_r;
  logic [DIMM_BUS_WIDTH-1:0] height_r;
  logic [DIMM_BUS_WIDTH-1:0] row;
  logic [DIMM_BUS_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0]     row_base;
  logic                      first_req;
  logic                      ovr_r;
  logic                      ack_r;
  logic [9*PIX_WIDTH-1:0]    win_r;

  // read issue side: (rd_j, rd_k) is the window column/row of the read on the bus
  logic                      en_r;
  logic [1:0]                rd_j;
  logic [1:0]                rd_k;
  // capture side: the same coordinates delayed by the BRAM latency
  logic                      cap_en;
  logic [1:0]                cap_j;
  logic [1:0]                cap_k;
  logic [3:0]                cap_idx;

  logic [ADDR_WIDTH-1:0]     width_a;
  logic [ADDR_WIDTH-1:0]     row_off;
  logic [ADDR_WIDTH-1:0]     addr_sum;
  logic                      col_ok;
  logic                      row_ok;
  logic                      col_step;

  // edge checks: next column needs col+1 <= width-3, next row needs row+1 <= height-3
  assign col_ok   = ({1'b0, col} + EDGE_STEP) <= {1'b0, width_r};
  assign row_ok   = ({1'b0, row} + EDGE_STEP) <= {1'b0, height_r};
  assign col_step = (state == S_IDLE) && req_pix && !first_req && !new_line && col_ok;

  assign width_a  = ADDR_WIDTH'(width_r);
  assign cap_idx  = ({2'b00, cap_k} * 4'd3) + {2'b00, cap_j};

  // row offset within the window without a multiplier: 0, width, 2*width
  always_comb begin
    row_off = '0;
    case (rd_k)
      2'd1:    row_off = width_a;
      2'd2:    row_off = width_a << 1;
      default: row_off = '0;
    endcase
  end

  assign addr_sum       = row_base + row_off + ADDR_WIDTH'(col) + ADDR_WIDTH'(rd_j);
  assign bram.bram_en   = en_r;
  assign bram.bram_addr = en_r ? addr_sum : '0;
  assign pix_ctrl_ack   = ack_r;
  assign overrun        = ovr_r;
  assign window         = win_r;

  // request FSM, frame position tracking and BRAM read sequencing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      width_r   <= '0;
      height_r  <= '0;
      row       <= '0;
      col       <= '0;
      row_base  <= '0;
      first_req <= 1'b1;
      ovr_r     <= 1'b0;
      ack_r     <= 1'b0;
      en_r      <= 1'b0;
      rd_j      <= '0;
      rd_k      <= '0;
      cap_en    <= 1'b0;
      cap_j     <= '0;
      cap_k     <= '0;
    end else if (start) begin
      state     <= S_IDLE;
      width_r   <= frame_input_width;
      height_r  <= frame_input_height;
      row       <= '0;
      col       <= '0;
      row_base  <= '0;
      first_req <= 1'b1;
      ovr_r     <= (frame_input_width < MIN_DIM) || (frame_input_height < MIN_DIM);
      ack_r     <= 1'b0;
      en_r      <= 1'b0;
      rd_j      <= '0;
      rd_k      <= '0;
      cap_en    <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_pix) begin
            if (first_req) begin
              row      <= '0;
              col      <= '0;
              row_base <= '0;
              rd_j     <= 2'd0;
              rd_k     <= 2'd0;
              en_r     <= 1'b1;
              state    <= S_LOAD;
            end else if (new_line) begin
              if (row_ok) begin
                row      <= row + DIMM_BUS_WIDTH'(1);
                col      <= '0;
                row_base <= row_base + width_a;
                rd_j     <= 2'd0;
                rd_k     <= 2'd0;
                en_r     <= 1'b1;
                state    <= S_LOAD;
              end else begin
                ovr_r <= 1'b1;
                ack_r <= 1'b1;
                state <= S_ACK;
              end
            end else begin
              if (col_ok) begin
                // column load only fetches the new rightmost window column
                col   <= col + DIMM_BUS_WIDTH'(1);
                rd_j  <= 2'd2;
                rd_k  <= 2'd0;
                en_r  <= 1'b1;
                state <= S_LOAD;
              end else begin
                ovr_r <= 1'b1;
                ack_r <= 1'b1;
                state <= S_ACK;
              end
            end
          end
        end
        S_LOAD: begin
          // walk rows 0..2 within a column, then the next column; stop after (2,2)
          if (en_r) begin
            if (rd_k != 2'd2) begin
              rd_k <= rd_k + 2'd1;
            end else if (rd_j != 2'd2) begin
              rd_k <= 2'd0;
              rd_j <= rd_j + 2'd1;
            end else begin
              en_r <= 1'b0;
            end
          end
          cap_en <= en_r;
          cap_j  <= rd_j;
          cap_k  <= rd_k;
          if (cap_en && (cap_j == 2'd2) && (cap_k == 2'd2)) begin
            ack_r <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          first_req <= 1'b0;
          state     <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!req_pix) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // window register: shift left on a column step, then fill from BRAM captures
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_r <= '0;
    end else if (!start) begin
      if (col_step) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_r[PIX_WIDTH*(3*r)   +: PIX_WIDTH] <= win_r[PIX_WIDTH*(3*r+1) +: PIX_WIDTH];
          win_r[PIX_WIDTH*(3*r+1) +: PIX_WIDTH] <= win_r[PIX_WIDTH*(3*r+2) +: PIX_WIDTH];
        end
      end else if ((state == S_LOAD) && cap_en) begin
        for (int unsigned i = 0; i < 9; i++) begin
          if (cap_idx == 4'(i)) win_r[PIX_WIDTH*i +: PIX_WIDTH] <= bram.bram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_loader.sv
// Self-checking bench for pixel_window_loader: directed vector table on a 5x4 frame,
// multi-cycle corner sequences, then random frames against a behavioural model.
module tb_pixel_window_loader;
  localparam int PW = 8;
  localparam int DW = 16;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] fw, fh;
  logic          start, req_pix, new_line;
  logic          pix_ctrl_ack, overrun;
  logic [9*PW-1:0] window;

  pixel_window_loader_if #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  pixel_window_loader #(.PIX_WIDTH(PW), .DIMM_BUS_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .frame_input_width (fw),
    .frame_input_height(fh),
    .start             (start),
    .req_pix           (req_pix),
    .new_line          (new_line),
    .pix_ctrl_ack      (pix_ctrl_ack),
    .window            (window),
    .bram              (bus),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  always @(posedge clk) if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr[11:0]];

  int addr_q[$];
  always @(negedge clk) if (bus.bram_en) addr_q.push_back(int'(bus.bram_addr));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [71:0] v;
    v = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  int  m_w, m_h, m_row, m_col;
  bit  m_first, m_ovr;
  logic [71:0] m_win;
  int  m_addrs[$];

  task automatic model_req(input bit nl, output int lat);
    bit full, ok;
    full = 0; ok = 1;
    m_addrs.delete();
    if (m_first) begin
      m_row = 0; m_col = 0; full = 1;
    end else if (nl) begin
      if (m_row + 1 > m_h - 3) ok = 0;
      else begin m_row++; m_col = 0; full = 1; end
    end else begin
      if (m_col + 1 > m_w - 3) ok = 0;
      else m_col++;
    end
    if (!ok) begin
      m_ovr = 1; lat = 1;
    end else begin
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++)
          if (full || j == 2) m_addrs.push_back((m_row + k) * m_w + m_col + j);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          m_win[8*(3*r+c) +: 8] = mem[((m_row + r) * m_w + m_col + c) & 4095];
      lat = full ? 11 : 5;
    end
    m_first = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input int w, input int h);
    @(negedge clk);
    fw = DW'(w); fh = DW'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_w = w; m_h = h; m_row = 0; m_col = 0; m_first = 1; m_ovr = (w < 3 || h < 3);
    check("start_overrun", overrun, m_ovr);
  endtask

  // issue one request, return ack latency in cycles after acceptance (0 = timeout)
  task automatic do_req(input bit nl, output int lat);
    @(negedge clk);
    addr_q.delete();
    req_pix = 1'b1; new_line = nl; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pix_ctrl_ack) begin lat = i; break; end
    end
    if (lat == 0) check("ack_timeout", 0, 1);
    req_pix = 1'b0; new_line = 1'b0;
    @(negedge clk);
    check("ack_single_cycle", pix_ctrl_ack, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_req(input bit nl);
    int elat, lat;
    model_req(nl, elat);
    do_req(nl, lat);
    check("rnd_latency", lat, elat);
    check("rnd_addr_count", addr_q.size(), m_addrs.size());
    for (int i = 0; i < m_addrs.size() && i < addr_q.size(); i++)
      check("rnd_addr", addr_q[i], m_addrs[i]);
    check("rnd_window", window, m_win);
    check("rnd_overrun", overrun, m_ovr);
  endtask

  typedef struct {
    bit          nl;
    int          lat;
    bit          ovr;
    int          naddr;
    logic [71:0] addrs;
    logic [71:0] win;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acks, ens, elat;
    resetn = 1'b0; start = 1'b0; req_pix = 1'b0; new_line = 1'b0; fw = '0; fh = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a);

    vecs[0] = '{1'b0, 11, 1'b0, 9, pack9(0, 5, 10, 1, 6, 11, 2, 7, 12), pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)};
    vecs[1] = '{1'b0,  5, 1'b0, 3, pack9(3, 8, 13, 0, 0, 0, 0, 0, 0),   pack9(1, 2, 3, 6, 7, 8, 11, 12, 13)};
    vecs[2] = '{1'b1, 11, 1'b0, 9, pack9(5, 10, 15, 6, 11, 16, 7, 12, 17), pack9(5, 6, 7, 10, 11, 12, 15, 16, 17)};
    vecs[3] = '{1'b0,  5, 1'b0, 3, pack9(8, 13, 18, 0, 0, 0, 0, 0, 0),  pack9(6, 7, 8, 11, 12, 13, 16, 17, 18)};
    vecs[4] = '{1'b0,  5, 1'b0, 3, pack9(9, 14, 19, 0, 0, 0, 0, 0, 0),  pack9(7, 8, 9, 12, 13, 14, 17, 18, 19)};
    vecs[5] = '{1'b0,  1, 1'b1, 0, '0,                                 pack9(7, 8, 9, 12, 13, 14, 17, 18, 19)};
    vecs[6] = '{1'b1,  1, 1'b1, 0, '0,                                 pack9(7, 8, 9, 12, 13, 14, 17, 18, 19)};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ack", pix_ctrl_ack, 0);
    check("rst_bram_en", bus.bram_en, 0);
    check("rst_bram_addr", bus.bram_addr, 0);
    check("rst_window", window, 0);
    check("rst_overrun", overrun, 0);
    resetn = 1'b1;

    // directed 5x4 frame, BRAM[a] = a
    start_frame(5, 4);
    for (int v = 0; v < 7; v++) begin
      do_req(vecs[v].nl, lat);
      check("vec_latency", lat, vecs[v].lat);
      check("vec_addr_count", addr_q.size(), vecs[v].naddr);
      for (int i = 0; i < vecs[v].naddr && i < addr_q.size(); i++)
        check("vec_addr", addr_q[i], vecs[v].addrs[8*i +: 8]);
      check("vec_window", window, vecs[v].win);
      check("vec_overrun", overrun, vecs[v].ovr);
    end
    start_frame(5, 4);
    check("start_clears_overrun", overrun, 0);

    // start in the middle of a full load aborts it with no ack
    @(negedge clk);
    req_pix = 1'b1; new_line = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; req_pix = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("abort_bram_en_off", bus.bram_en, 0);
    acks = 0; ens = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pix_ctrl_ack) acks++;
      if (bus.bram_en) ens++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_no_reads", ens, 0);
    m_first = 1; m_ovr = 0; m_row = 0; m_col = 0;
    check_req(1'b0);

    // request held long after ack produces exactly one ack
    model_req(1'b0, elat);
    @(negedge clk);
    addr_q.delete();
    req_pix = 1'b1;
    acks = 0;
    for (int i = 0; i < elat + 10; i++) begin
      @(negedge clk);
      if (pix_ctrl_ack) acks++;
    end
    req_pix = 1'b0;
    repeat (3) @(negedge clk);
    check("held_req_one_ack", acks, 1);
    check("held_req_reads", addr_q.size(), m_addrs.size());
    check("held_req_window", window, m_win);

    // asynchronous reset in the middle of a load
    start_frame(5, 4);
    @(negedge clk);
    req_pix = 1'b1;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("arst_ack", pix_ctrl_ack, 0);
    check("arst_bram_en", bus.bram_en, 0);
    check("arst_bram_addr", bus.bram_addr, 0);
    check("arst_window", window, 0);
    check("arst_overrun", overrun, 0);
    req_pix = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pix_ctrl_ack) acks++;
    end
    check("arst_no_ack", acks, 0);
    resetn = 1'b1;

    // undersized frames flag overrun at start
    start_frame(2, 6);
    start_frame(7, 2);

    // random frames against the model
    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
      start_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 9)));
      for (int n = 0; n < 25; n++) check_req($urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
